// File: rtl/ndn_prefix_parser_if.sv
// Byte-stream ingress plus FIB/PIT prefix and payload egress of ndn_prefix_parser.
// master = packet source / downstream consumer side, slave = the parser itself.
interface ndn_prefix_parser_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_last;
    logic        rx_ready;

    logic [63:0] data_in_prefix;
    logic [5:0]  data_in_len;
    logic        data_ready;
    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        interest_ready;

    logic [7:0]  data_in;
    logic        payload_valid;
    logic        payload_last;
    logic        parse_error;

    modport master (
        output rx_valid,
        output rx_byte,
        output rx_last,
        input  rx_ready,
        input  data_in_prefix,
        input  data_in_len,
        input  data_ready,
        input  pit_in_prefix,
        input  pit_in_len,
        input  interest_ready,
        input  data_in,
        input  payload_valid,
        input  payload_last,
        input  parse_error
    );

    modport slave (
        input  rx_valid,
        input  rx_byte,
        input  rx_last,
        output rx_ready,
        output data_in_prefix,
        output data_in_len,
        output data_ready,
        output pit_in_prefix,
        output pit_in_len,
        output interest_ready,
        output data_in,
        output payload_valid,
        output payload_last,
        output parse_error
    );
endinterface

// File: rtl/ndn_prefix_parser.sv
// Byte-serial NDN header parser: emits left-aligned Data/Interest prefixes, forwards payload.
// Define PARSER_STATS_EN to add saturating pkt_count / err_count outputs.
module ndn_prefix_parser #(
    parameter logic [7:0] INTEREST_TYPE = 8'h05,
    parameter logic [7:0] DATA_TYPE     = 8'h06
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PARSER_STATS_EN
    output logic [15:0]        pkt_count,
    output logic [15:0]        err_count,
`endif
    ndn_prefix_parser_if.slave bus
);

    typedef enum logic [2:0] {
        ST_TYPE,
        ST_LEN,
        ST_PREFIX,
        ST_EMIT,
        ST_PAYLOAD,
        ST_DROP
    } state_e;

    state_e      state_q, state_d;
    logic        is_interest_q, is_interest_d;
    logic        last_q, last_d;
    logic [5:0]  len_q, len_d;
    logic [3:0]  need_q, need_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] prefix_q, prefix_d;

    logic [63:0] data_in_prefix_q, data_in_prefix_d;
    logic [5:0]  data_in_len_q, data_in_len_d;
    logic        data_ready_q, data_ready_d;
    logic [63:0] pit_in_prefix_q, pit_in_prefix_d;
    logic [5:0]  pit_in_len_q, pit_in_len_d;
    logic        interest_ready_q, interest_ready_d;
    logic [7:0]  data_in_q, data_in_d;
    logic        payload_valid_q, payload_valid_d;
    logic        payload_last_q, payload_last_d;
    logic        parse_error_q, parse_error_d;

    logic        accept;
    logic        emit_go;
    logic        err_go;
    logic [63:0] emit_prefix;
    logic [5:0]  emit_len;
    logic [63:0] merged;

    // Keep only the top n bits; n == 0 yields an all-zero prefix.
    function automatic logic [63:0] keep_top(input logic [63:0] p, input logic [5:0] n);
        return p & ~({64{1'b1}} >> n);
    endfunction

    assign accept = bus.rx_valid && (state_q != ST_EMIT);

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        state_d          = state_q;
        is_interest_d    = is_interest_q;
        last_d           = last_q;
        len_d            = len_q;
        need_d           = need_q;
        cnt_d            = cnt_q;
        prefix_d         = prefix_q;
        data_in_prefix_d = data_in_prefix_q;
        data_in_len_d    = data_in_len_q;
        data_ready_d     = 1'b0;
        pit_in_prefix_d  = pit_in_prefix_q;
        pit_in_len_d     = pit_in_len_q;
        interest_ready_d = 1'b0;
        data_in_d        = data_in_q;
        payload_valid_d  = 1'b0;
        payload_last_d   = 1'b0;
        parse_error_d    = 1'b0;
        emit_go          = 1'b0;
        err_go           = 1'b0;
        emit_prefix      = '0;
        emit_len         = '0;

        // Prefix byte k lands at [63-8k -: 8]; ~k on three bits is 7-k.
        merged = prefix_q;
        merged[{~cnt_q[2:0], 3'b000} +: 8] = bus.rx_byte;

        unique case (state_q)
            ST_TYPE: begin
                if (accept) begin
                    if (bus.rx_last ||
                        (bus.rx_byte != INTEREST_TYPE && bus.rx_byte != DATA_TYPE)) begin
                        err_go = 1'b1;
                    end else begin
                        is_interest_d = (bus.rx_byte == INTEREST_TYPE);
                        state_d       = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (bus.rx_byte[7:6] != 2'b00) begin
                        err_go = 1'b1;
                    end else if (bus.rx_byte[5:0] == 6'd0) begin
                        emit_go = 1'b1;
                    end else if (bus.rx_last) begin
                        err_go = 1'b1;
                    end else begin
                        len_d    = bus.rx_byte[5:0];
                        need_d   = 4'((7'(bus.rx_byte[5:0]) + 7'd7) >> 3);
                        cnt_d    = '0;
                        prefix_d = '0;
                        state_d  = ST_PREFIX;
                    end
                end
            end
            ST_PREFIX: begin
                if (accept) begin
                    prefix_d = merged;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == need_q) begin
                        emit_go     = 1'b1;
                        emit_prefix = keep_top(merged, len_q);
                        emit_len    = len_q;
                    end else if (bus.rx_last) begin
                        err_go = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                state_d = last_q ? ST_TYPE : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    data_in_d       = bus.rx_byte;
                    payload_valid_d = 1'b1;
                    payload_last_d  = bus.rx_last;
                    if (bus.rx_last) state_d = ST_TYPE;
                end
            end
            ST_DROP: begin
                if (accept && bus.rx_last) state_d = ST_TYPE;
            end
            default: state_d = ST_TYPE;
        endcase

        if (emit_go) begin
            state_d = ST_EMIT;
            last_d  = bus.rx_last;
            if (is_interest_q) begin
                pit_in_prefix_d  = emit_prefix;
                pit_in_len_d     = emit_len;
                interest_ready_d = 1'b1;
            end else begin
                data_in_prefix_d = emit_prefix;
                data_in_len_d    = emit_len;
                data_ready_d     = 1'b1;
            end
        end

        if (err_go) begin
            parse_error_d = 1'b1;
            state_d       = bus.rx_last ? ST_TYPE : ST_DROP;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_TYPE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_interest_q    <= 1'b0;
            last_q           <= 1'b0;
            len_q            <= '0;
            need_q           <= '0;
            cnt_q            <= '0;
            prefix_q         <= '0;
            data_in_prefix_q <= '0;
            data_in_len_q    <= '0;
            data_ready_q     <= 1'b0;
            pit_in_prefix_q  <= '0;
            pit_in_len_q     <= '0;
            interest_ready_q <= 1'b0;
            data_in_q        <= '0;
            payload_valid_q  <= 1'b0;
            payload_last_q   <= 1'b0;
            parse_error_q    <= 1'b0;
        end else begin
            is_interest_q    <= is_interest_d;
            last_q           <= last_d;
            len_q            <= len_d;
            need_q           <= need_d;
            cnt_q            <= cnt_d;
            prefix_q         <= prefix_d;
            data_in_prefix_q <= data_in_prefix_d;
            data_in_len_q    <= data_in_len_d;
            data_ready_q     <= data_ready_d;
            pit_in_prefix_q  <= pit_in_prefix_d;
            pit_in_len_q     <= pit_in_len_d;
            interest_ready_q <= interest_ready_d;
            data_in_q        <= data_in_d;
            payload_valid_q  <= payload_valid_d;
            payload_last_q   <= payload_last_d;
            parse_error_q    <= parse_error_d;
        end
    end

    assign bus.rx_ready       = (state_q != ST_EMIT);
    assign bus.data_in_prefix = data_in_prefix_q;
    assign bus.data_in_len    = data_in_len_q;
    assign bus.data_ready     = data_ready_q;
    assign bus.pit_in_prefix  = pit_in_prefix_q;
    assign bus.pit_in_len     = pit_in_len_q;
    assign bus.interest_ready = interest_ready_q;
    assign bus.data_in        = data_in_q;
    assign bus.payload_valid  = payload_valid_q;
    assign bus.payload_last   = payload_last_q;
    assign bus.parse_error    = parse_error_q;

`ifdef PARSER_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (state_q == ST_EMIT && pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
        if (parse_error_q && err_count_q != 16'hFFFF)      err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`else
    // Statistics compiled out: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_ndn_prefix_parser.sv
// Self-checking bench for ndn_prefix_parser: directed packets plus randomized traffic
// compared against a packet-level reference model.
module tb_ndn_prefix_parser;
    localparam logic [7:0] INTEREST_TYPE = 8'h05;
    localparam logic [7:0] DATA_TYPE     = 8'h06;

    typedef struct {
        logic        is_interest;
        logic [63:0] prefix;
        logic [5:0]  len;
    } strobe_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } pay_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ndn_prefix_parser_if bus ();

`ifdef PARSER_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] err_count;
`endif

    ndn_prefix_parser #(
        .INTEREST_TYPE (INTEREST_TYPE),
        .DATA_TYPE     (DATA_TYPE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PARSER_STATS_EN
        .pkt_count (pkt_count),
        .err_count (err_count),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    strobe_t exp_s[$];
    strobe_t got_s[$];
    pay_t    exp_p[$];
    pay_t    got_p[$];
    int      exp_err  = 0;
    int      got_err  = 0;
    int      stat_pkt = 0;
    int      stat_err = 0;

    logic [63:0] held_data_prefix = '0;
    logic [5:0]  held_data_len    = '0;
    logic [63:0] held_pit_prefix  = '0;
    logic [5:0]  held_pit_len     = '0;

    logic [7:0] pkt_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.data_ready)     got_s.push_back('{1'b0, bus.data_in_prefix, bus.data_in_len});
        if (bus.interest_ready) got_s.push_back('{1'b1, bus.pit_in_prefix, bus.pit_in_len});
        if (bus.payload_valid)  got_p.push_back('{bus.data_in, bus.payload_last});
        if (bus.parse_error)    got_err++;
        check("ready_low_only_in_emit", 64'(bus.rx_ready),
              64'(!(bus.data_ready || bus.interest_ready)));
        check("strobes_exclusive", 64'(bus.data_ready && bus.interest_ready), 64'd0);
    end

    // Reference model: whole-packet view of the framing rules.
    task automatic model_packet();
        int          n;
        int          len;
        int          need;
        logic [7:0]  lb;
        logic [63:0] p;
        n = pkt_q.size();
        p = '0;
        if (n < 2 || (pkt_q[0] != INTEREST_TYPE && pkt_q[0] != DATA_TYPE)) begin
            exp_err++;
            stat_err++;
            return;
        end
        lb = pkt_q[1];
        if (lb[7:6] != 2'b00) begin
            exp_err++;
            stat_err++;
            return;
        end
        len  = int'(lb[5:0]);
        need = (len + 7) / 8;
        if (n < 2 + need) begin
            exp_err++;
            stat_err++;
            return;
        end
        for (int k = 0; k < need; k++) p = p | (64'(pkt_q[2 + k]) << (56 - 8 * k));
        if (len == 0) p = '0;
        else          p = (p >> (64 - len)) << (64 - len);
        exp_s.push_back('{pkt_q[0] == INTEREST_TYPE, p, 6'(len)});
        if (pkt_q[0] == INTEREST_TYPE) begin
            held_pit_prefix = p;
            held_pit_len    = 6'(len);
        end else begin
            held_data_prefix = p;
            held_data_len    = 6'(len);
        end
        stat_pkt++;
        for (int i = 2 + need; i < n; i++) exp_p.push_back('{pkt_q[i], i == n - 1});
    endtask

    task automatic add(input logic [7:0] b);
        pkt_q.push_back(b);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gmin, input int gmax);
        int   gaps;
        logic taken;
        gaps  = (gmax > 0) ? int'($urandom_range(gmax, gmin)) : 0;
        taken = 1'b0;
        repeat (gaps) begin
            bus.rx_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        bus.rx_last  = last;
        for (int t = 0; t < 8 && !taken; t++) begin
            @(negedge clk);
            taken = bus.rx_ready;
            @(posedge clk);
            #1;
        end
        check("byte_accepted", 64'(taken), 64'd1);
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'b0;
    endtask

    task automatic send_packet(input int gmin, input int gmax);
        for (int i = 0; i < pkt_q.size(); i++)
            send_byte(pkt_q[i], i == pkt_q.size() - 1, gmin, gmax);
        model_packet();
    endtask

    task automatic checkpoint(input string tag);
        strobe_t g;
        strobe_t e;
        pay_t    gp;
        pay_t    ep;
        bus.rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, ":strobe_count"}, 64'(got_s.size()), 64'(exp_s.size()));
        while (got_s.size() > 0 && exp_s.size() > 0) begin
            g = got_s.pop_front();
            e = exp_s.pop_front();
            check({tag, ":strobe_kind"},   64'(g.is_interest), 64'(e.is_interest));
            check({tag, ":strobe_prefix"}, g.prefix,           e.prefix);
            check({tag, ":strobe_len"},    64'(g.len),         64'(e.len));
        end
        got_s.delete();
        exp_s.delete();
        check({tag, ":payload_count"}, 64'(got_p.size()), 64'(exp_p.size()));
        while (got_p.size() > 0 && exp_p.size() > 0) begin
            gp = got_p.pop_front();
            ep = exp_p.pop_front();
            check({tag, ":payload_byte"}, 64'(gp.b),    64'(ep.b));
            check({tag, ":payload_last"}, 64'(gp.last), 64'(ep.last));
        end
        got_p.delete();
        exp_p.delete();
        check({tag, ":parse_errors"},  64'(got_err),            64'(exp_err));
        check({tag, ":held_data_pfx"}, bus.data_in_prefix,      held_data_prefix);
        check({tag, ":held_data_len"}, 64'(bus.data_in_len),    64'(held_data_len));
        check({tag, ":held_pit_pfx"},  bus.pit_in_prefix,       held_pit_prefix);
        check({tag, ":held_pit_len"},  64'(bus.pit_in_len),     64'(held_pit_len));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":rx_ready"},       64'(bus.rx_ready),       64'd1);
        check({tag, ":data_prefix"},    bus.data_in_prefix,      64'd0);
        check({tag, ":data_len"},       64'(bus.data_in_len),    64'd0);
        check({tag, ":data_ready"},     64'(bus.data_ready),     64'd0);
        check({tag, ":pit_prefix"},     bus.pit_in_prefix,       64'd0);
        check({tag, ":pit_len"},        64'(bus.pit_in_len),     64'd0);
        check({tag, ":interest_ready"}, 64'(bus.interest_ready), 64'd0);
        check({tag, ":data_in"},        64'(bus.data_in),        64'd0);
        check({tag, ":payload_valid"},  64'(bus.payload_valid),  64'd0);
        check({tag, ":payload_last"},   64'(bus.payload_last),   64'd0);
        check({tag, ":parse_error"},    64'(bus.parse_error),    64'd0);
`ifdef PARSER_STATS_EN
        check({tag, ":pkt_count"},      64'(pkt_count),          64'd0);
        check({tag, ":err_count"},      64'(err_count),          64'd0);
`endif
    endtask

    task automatic build_data_pkt1();
        pkt_q.delete();
        add(8'h06); add(8'h0A); add(8'hFF); add(8'hFF); add(8'h11); add(8'h22);
    endtask

    task automatic random_packet();
        int         sel;
        int         need;
        int         npay;
        logic [7:0] lb;
        pkt_q.delete();
        sel = int'($urandom_range(9, 0));
        if (sel < 4)      add(DATA_TYPE);
        else if (sel < 8) add(INTEREST_TYPE);
        else              add(8'($urandom));
        sel = int'($urandom_range(9, 0));
        if (sel == 0)      lb = 8'($urandom_range(255, 64));
        else if (sel == 1) lb = 8'h00;
        else               lb = {2'b00, 6'($urandom)};
        add(lb);
        need = (int'(lb[5:0]) + 7) / 8;
        for (int k = 0; k < need; k++) add(8'($urandom));
        npay = int'($urandom_range(4, 0));
        for (int k = 0; k < npay; k++) add(8'($urandom));
        if ($urandom_range(7, 0) == 0) begin
            int keep;
            keep = int'($urandom_range(pkt_q.size() - 1, 1));
            while (pkt_q.size() > keep) void'(pkt_q.pop_back());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("after_release");

        // Data packet with a 10-bit prefix and two payload bytes.
        build_data_pkt1();
        send_packet(0, 0);
        checkpoint("data_pkt");
        check("data_pkt:prefix_value", bus.data_in_prefix,   64'hFFC0_0000_0000_0000);
        check("data_pkt:len_value",    64'(bus.data_in_len), 64'd10);
        check("data_pkt:pit_untouched", 64'(bus.pit_in_len), 64'd0);

        // Interest packet with a full 63-bit prefix.
        pkt_q.delete();
        add(8'h05); add(8'h3F);
        repeat (8) add(8'hA5);
        add(8'h01);
        send_packet(0, 0);
        checkpoint("interest_pkt");
        check("interest_pkt:prefix_value", bus.pit_in_prefix,   64'hA5A5_A5A5_A5A5_A5A4);
        check("interest_pkt:len_value",    64'(bus.pit_in_len), 64'd63);

        // Zero-length prefix ending on the length byte, then a packet back-to-back.
        pkt_q.delete();
        add(8'h06); add(8'h00);
        send_packet(0, 0);
        pkt_q.delete();
        add(8'h06); add(8'h08); add(8'h5A); add(8'h77);
        send_packet(0, 0);
        checkpoint("zero_len_b2b");
        check("zero_len_b2b:prefix_value", bus.data_in_prefix,   64'h5A00_0000_0000_0000);
        check("zero_len_b2b:len_value",    64'(bus.data_in_len), 64'd8);

        // Malformed packets: unknown type, length upper bits, truncated prefix.
        pkt_q.delete();
        add(8'h07); add(8'h11); add(8'h22);
        send_packet(0, 0);
        pkt_q.delete();
        add(8'h06); add(8'h4A); add(8'h01); add(8'h02);
        send_packet(0, 0);
        pkt_q.delete();
        add(8'h06); add(8'h10); add(8'hAB);
        send_packet(0, 0);
        checkpoint("malformed");
        check("malformed:error_total", 64'(got_err), 64'd3);

        // First packet again with bubbles between every byte.
        build_data_pkt1();
        send_packet(1, 3);
        checkpoint("data_pkt_gaps");
        check("data_pkt_gaps:prefix_value", bus.data_in_prefix, 64'hFFC0_0000_0000_0000);

        // Reset in the middle of the prefix, then a clean packet.
        pkt_q.delete();
        add(8'h06); add(8'h20); add(8'hAA); add(8'hBB);
        for (int i = 0; i < pkt_q.size(); i++) send_byte(pkt_q[i], 1'b0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        held_data_prefix = '0;
        held_data_len    = '0;
        held_pit_prefix  = '0;
        held_pit_len     = '0;
        stat_pkt         = 0;
        stat_err         = 0;
        @(posedge clk);
        #1;
        pkt_q.delete();
        add(8'h06); add(8'h18); add(8'hC3); add(8'h3C); add(8'h99); add(8'h5A);
        send_packet(0, 0);
        checkpoint("after_reset");
        check("after_reset:prefix_value", bus.data_in_prefix,   64'hC33C_9900_0000_0000);
        check("after_reset:len_value",    64'(bus.data_in_len), 64'd24);
`ifdef PARSER_STATS_EN
        check("after_reset:pkt_count", 64'(pkt_count), 64'd1);
        check("after_reset:err_count", 64'(err_count), 64'd0);
`endif

        // Randomized traffic with occasional bad types, lengths and truncation.
        for (int p = 0; p < 300; p++) begin
            random_packet();
            send_packet(0, int'($urandom_range(2, 0)));
            if (p % 25 == 24) checkpoint("random");
        end
        checkpoint("random_end");
`ifdef PARSER_STATS_EN
        check("random_end:pkt_count", 64'(pkt_count), 64'(stat_pkt));
        check("random_end:err_count", 64'(err_count), 64'(stat_err));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
